// File: rtl/pulse_gen_pkg.sv
// Purpose: shared sizing helpers for free-running timers and strobe generators.
// Latency: n/a (elaboration-time constants only).
// Backpressure: n/a.
package pulse_gen_pkg;

  // Counter width for a modulo-p counter; at least one bit so a 1-cycle period still has a flop.
  function automatic int cnt_width(input int p);
    int w;
    w = $clog2(p);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : pulse_gen_pkg

// File: rtl/pulse_generator_mod_n_counter.sv
// Purpose: modulo-N up-counter with synchronous clear and a combinational terminal-count flag.
// Latency: cnt updates one edge after en/clr; wrap is combinational from en and the current count.
// Backpressure: none; en gates counting, clr forces the count back to zero and wins over en.
module mod_n_counter
  import pulse_gen_pkg::*;
#(
  parameter int N = 5,
  localparam int CNT_W = cnt_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  // Terminal count held as a CNT_W-bit constant so the compare has no width mismatch.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear restarts the phase, otherwise step and fold back to zero after LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = en && (cnt_q == LAST);

endmodule : mod_n_counter

// File: rtl/pulse_generator.sv
// Purpose: periodic one-cycle strobe, asserted once every PERIOD enabled clk cycles.
// Latency: first strobe is registered after the PERIOD-th consecutive enabled edge.
// Backpressure: none; dropping enable clears the phase and the next run starts a full period.
module pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int PERIOD = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic pulse_out
);

  localparam int CNT_W = cnt_width(PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  // A period below one cycle has no meaningful strobe; stop at elaboration.
  generate
    if (PERIOD < 1) begin : g_bad_period
      $error("pulse_generator: PERIOD must be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             pulse_d;
  logic             pulse_q;

  mod_n_counter #(
    .N(PERIOD)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (enable),
    .clr  (~enable),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // The strobe is the terminal-count flag delayed by one flop so the port is glitch-free.
  always_comb begin
    pulse_d = wrap;
  end

  // Strobe register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign pulse_out = pulse_q;

  // The phase counter must never step past the terminal count.
  a_cnt_in_range : assert property (@(posedge clk) disable iff (!reset) cnt <= LAST);

  // With more than one cycle per period a strobe can never last two cycles.
  generate
    if (PERIOD > 1) begin : g_width_chk
      a_one_cycle : assert property (@(posedge clk) disable iff (!reset) pulse_q |=> !pulse_q);
    end
  endgenerate

endmodule : pulse_generator

// File: tb/tb_pulse_generator.sv
module tb_pulse_generator;

  logic clk;
  logic reset;
  logic enable;
  logic en1;
  logic en2;
  logic pulse5;
  logic pulse1;
  logic pulse2;

  int tests;
  int fails;
  logic prev5;

  typedef struct {
    logic       r;
    logic       e;
    logic       p;
    logic [2:0] c;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  pulse_generator #(5) u_p5 (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pulse_out(pulse5)
  );

  pulse_generator #(1) u_p1 (
    .clk      (clk),
    .reset    (reset),
    .enable   (en1),
    .pulse_out(pulse1)
  );

  pulse_generator #(2) u_p2 (
    .clk      (clk),
    .reset    (reset),
    .enable   (en2),
    .pulse_out(pulse2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic p, input logic [2:0] c,
                     input string tag);
    vec_t v;
    v.r = r; v.e = e; v.p = p; v.c = c; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    prev5  = 1'b0;
    reset  = 1'b0;
    enable = 1'b0;
    en1    = 1'b0;
    en2    = 1'b0;

    // 1: reset held with enable high
    add(0, 1, 0, 0, "reset_hold");
    add(0, 1, 0, 0, "reset_hold");
    // 2: 20 enabled edges, strobe after edges 5,10,15,20
    for (int k = 1; k <= 20; k++) add(1, 1, logic'(k % 5 == 0), 3'(k % 5), "run20");
    // 3: 7 on, 3 off, 6 on
    add(1, 1, 0, 1, "gap_on");  add(1, 1, 0, 2, "gap_on");  add(1, 1, 0, 3, "gap_on");
    add(1, 1, 0, 4, "gap_on");  add(1, 1, 1, 0, "gap_on");  add(1, 1, 0, 1, "gap_on");
    add(1, 1, 0, 2, "gap_on");
    add(1, 0, 0, 0, "gap_off"); add(1, 0, 0, 0, "gap_off"); add(1, 0, 0, 0, "gap_off");
    add(1, 1, 0, 1, "gap_re");  add(1, 1, 0, 2, "gap_re");  add(1, 1, 0, 3, "gap_re");
    add(1, 1, 0, 4, "gap_re");  add(1, 1, 1, 0, "gap_re");  add(1, 1, 0, 1, "gap_re");
    // 4: reset mid-count with enable held, then a full period after release
    add(1, 1, 0, 2, "mid_pre"); add(1, 1, 0, 3, "mid_pre");
    add(0, 1, 0, 0, "mid_rst");
    add(1, 1, 0, 1, "mid_rel"); add(1, 1, 0, 2, "mid_rel"); add(1, 1, 0, 3, "mid_rel");
    add(1, 1, 0, 4, "mid_rel"); add(1, 1, 1, 0, "mid_rel");
    // 6: disable exactly when cnt==4, then re-enable starts from zero
    add(1, 1, 0, 1, "drop4");   add(1, 1, 0, 2, "drop4");   add(1, 1, 0, 3, "drop4");
    add(1, 1, 0, 4, "drop4");
    add(1, 0, 0, 0, "drop4_off");
    add(1, 1, 0, 1, "drop4_re");
    // enable dropping on a strobe cycle: strobe clears on the next edge
    add(1, 1, 0, 2, "dp_on");   add(1, 1, 0, 3, "dp_on");   add(1, 1, 0, 4, "dp_on");
    add(1, 1, 1, 0, "dp_on");
    add(1, 0, 0, 0, "dp_off");

    foreach (vecs[i]) begin
      reset  = vecs[i].r;
      enable = vecs[i].e;
      @(posedge clk);
      #1;
      tests++;
      if (pulse5 !== vecs[i].p) begin
        fails++;
        $display("FAIL %s[%0d] pulse_out: got %b, expected %b", vecs[i].tag, i, pulse5, vecs[i].p);
      end
      tests++;
      if (u_p5.u_cnt.cnt !== vecs[i].c) begin
        fails++;
        $display("FAIL %s[%0d] cnt: got %0d, expected %0d", vecs[i].tag, i, u_p5.u_cnt.cnt,
                 vecs[i].c);
      end
      if (vecs[i].r) begin
        tests++;
        if (prev5 && pulse5) begin
          fails++;
          $display("FAIL %s[%0d] pulse_width: got 2+ cycles, expected 1", vecs[i].tag, i);
        end
      end
      prev5 = pulse5;
    end

    // 5: PERIOD=1 strobes every enabled cycle, PERIOD=2 alternates 0,1,0,1
    reset  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en1 = 1'b1;
      en2 = 1'b1;
      @(posedge clk);
      #1;
      check_bit($sformatf("p1_run[%0d]", i), pulse1, 1'b1);
      check_bit($sformatf("p2_run[%0d]", i), pulse2, logic'(i % 2 == 1));
    end
    en1 = 1'b0;
    en2 = 1'b0;
    @(posedge clk);
    #1;
    check_bit("p1_off", pulse1, 1'b0);
    check_bit("p2_off", pulse2, 1'b0);

    // Reset wins over enable even for a 1-cycle period
    reset = 1'b0;
    en1   = 1'b1;
    @(posedge clk);
    #1;
    check_bit("p1_rst_prio", pulse1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_bit("p1_after_rst", pulse1, 1'b1);
    en1 = 1'b0;
    @(posedge clk);
    #1;
    check_bit("p1_final_off", pulse1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pulse_generator
